piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in serial-out framed transmitter. It is the driving end of the serial bit stream that the shift-register chain consumes on its serial D input.
- It accepts a parallel word over a valid/ready handshake and emits it one bit per clock on sout: start bit, data bits, optional parity bit, stop bit.
- It sits between a word-producing block and any serial shift-register or receiver input.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2..32).
- MSB_FIRST, 1, 1 = data bit WIDTH-1 sent first; 0 = bit 0 sent first.
- PARITY_EN, 0, 1 = insert one parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  registered serial output.
- busy  output  1  a frame is in progress (state is not IDLE).
- frame_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, sout=0 (idle level), busy=0, frame_done=0, bit counter=0, shift register=0.
- While rst=1, din_ready=0. Otherwise din_ready = (state==IDLE) or (state==STOP).
- Handshake: a word is accepted at a rising edge where din_valid=1 and din_ready=1.
  - On acceptance, din is latched into the shift register.
  - din may change on the following cycle.
  - din_valid while din_ready=0 is ignored; no word is latched.
- Frame format, one bit per clock, all registered:
  - start bit = 1;
  - WIDTH data bits in MSB_FIRST order;
  - parity bit, only if PARITY_EN=1;
  - stop bit = 0.
- Frame length is WIDTH+2 cycles, or WIDTH+3 with parity.
- Latency: the start bit appears on sout in the cycle immediately after the acceptance edge.
- State machine, one state per bit period:
  - IDLE: sout=0, busy=0. On accept -> START.
  - START: sout=1 for one cycle -> DATA, with counter=0.
  - DATA: sout = current data bit. The counter increments every cycle. On the cycle where counter==WIDTH-1, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: sout = XOR of the latched word, inverted when PARITY_ODD=1. One cycle -> STOP.
  - STOP: sout=0 and frame_done=1 for this cycle. On accept -> START (back-to-back, no idle gap); else -> IDLE.
- Parity is computed from the latched word, never from live din.
- Counter width is clog2(WIDTH). It resets to 0 on every entry to DATA and never wraps mid-frame.
- Reset asserted mid-frame: the frame is abandoned. On the next edge all outputs take their reset values and sout returns to 0. No frame_done pulse is generated for the abandoned frame.
- din_valid held high continuously: frames stream back-to-back. Each frame's start bit directly follows the previous stop bit.
- frame_done is never asserted outside STOP.
- busy is 1 in START, DATA, PARITY and STOP.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release with din_valid=0 -> sout=0, busy=0, din_ready=1 and frame_done=0 for 20 cycles.
- Basic MSB-first frame (WIDTH=8, MSB_FIRST=1, PARITY_EN=0): din=8'hB1 accepted -> sout over the next 10 cycles is 1,1,0,1,1,0,0,0,1,0; frame_done pulses once, on the 10th cycle; then busy=0.
- LSB-first with even parity (MSB_FIRST=0, PARITY_EN=1, PARITY_ODD=0): din=8'hB1 -> sout is 1,1,0,0,0,1,1,0,1,0,0 (parity bit 0, four ones); with PARITY_ODD=1 the parity bit is 1.
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C -> second start bit directly follows the first stop bit; din_ready=1 only during IDLE/STOP; 20 contiguous frame bits with no idle cycle between frames.
- Input change during frame: accept 8'hFF, drive din=8'h00 with din_valid=1 during DATA -> data bits stay all 1; 8'h00 is accepted only at the STOP edge and sent as the next frame.
- Mid-frame reset: assert rst during data bit 4 of 8'hB1 -> next cycle sout=0, busy=0, no frame_done pulse; after release, a new word 8'h0F transmits a complete, correct frame.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: framed parallel-in serial-out transmitter.
// Accepts a word over valid/ready and sends it one bit per clock on sout as
// start(1), WIDTH data bits, optional parity, stop(0). sout idles low.
// A new word may be accepted during the stop bit, so frames can run
// back-to-back with no idle cycle between them.
module piso_tx #(
  parameter int WIDTH      = 8,     // data bits per frame, 2..32
  parameter bit MSB_FIRST  = 1'b1,  // 1: bit WIDTH-1 goes out first
  parameter bit PARITY_EN  = 1'b0,  // 1: parity bit after the data bits
  parameter bit PARITY_ODD = 1'b0   // parity sense: 0 even, 1 odd
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             frame_done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  // One state per bit period on the line.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             fd_q, fd_d;
  logic             accept;
  logic [CW-1:0]    bit_idx;

  // Words are taken only when the line is idle or on the final (stop) bit,
  // and never while reset is held.
  assign din_ready = !rst && ((state_q == IDLE) || (state_q == STOP));
  assign accept    = din_valid && din_ready;

  // Next-state logic: latch the word on accept, count data bits in DATA.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = din;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = PARITY_EN ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        if (accept) begin
          state_d = START;
          shreg_d = din;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line value for the upcoming bit period. It is derived from the next
  // state so that sout can be a plain flop aligned with state_q.
  always_comb begin
    sout_d  = 1'b0;
    fd_d    = 1'b0;
    bit_idx = MSB_FIRST ? (CNT_LAST - cnt_d) : cnt_d;
    case (state_d)
      START:   sout_d = 1'b1;
      DATA:    sout_d = shreg_d[bit_idx];
      // Parity is taken from the latched word; din may already have moved on.
      PARITY:  sout_d = (^shreg_d) ^ PARITY_ODD;
      STOP: begin
        sout_d = 1'b0;
        fd_d   = 1'b1;
      end
      default: sout_d = 1'b0;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sout_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      fd_q    <= fd_d;
    end
  end

  assign sout       = sout_q;
  assign frame_done = fd_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: three piso_tx variants (MSB-first no parity, LSB-first even
// parity, LSB-first odd parity) share one stimulus stream. A frame-list
// model predicts every output each cycle; directed windows compare sout
// against hand-written bit patterns.
module tb_piso_tx;
  localparam int W = 8;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic [N-1:0] sout_a, busy_a, rdy_a, fd_a;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    piso_tx #(
      .WIDTH(W), .MSB_FIRST(g == 0), .PARITY_EN(g != 0), .PARITY_ODD(g == 2)
    ) u_dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(rdy_a[g]), .sout(sout_a[g]), .busy(busy_a[g]),
      .frame_done(fd_a[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each variant holds the list of line bits of its current frame (index 0
  // is the start bit) and the position on the line, -1 when idle.
  function automatic int flen(input int k);
    return (k == 0) ? W + 2 : W + 3;
  endfunction

  function automatic logic [15:0] build(input logic [W-1:0] w, input int k);
    logic [15:0] f = '0;
    f[0] = 1'b1;
    for (int i = 0; i < W; i++) f[1+i] = (k == 0) ? w[W-1-i] : w[i];
    if (k != 0) f[W+1] = (($countones(w) % 2) == 1) ^ (k == 2);
    return f;  // stop bit at flen-1 stays 0
  endfunction

  int          pos_q[N];
  logic [15:0] bits_q[N];
  bit          armed = 1'b0;

  function automatic logic exp_rdy(input int k);
    return !rst && (pos_q[k] < 0 || pos_q[k] == flen(k) - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    for (int k = 0; k < N; k++) begin
      if (rst) pos_q[k] <= -1;
      else if (din_valid && exp_rdy(k)) begin
        bits_q[k] <= build(din, k);
        pos_q[k]  <= 0;
      end else if (pos_q[k] >= 0)
        pos_q[k] <= (pos_q[k] == flen(k) - 1) ? -1 : pos_q[k] + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("sout%0d", k), 32'(sout_a[k]),
            (pos_q[k] < 0) ? 32'd0 : 32'(bits_q[k][pos_q[k]]));
        chk($sformatf("busy%0d", k), 32'(busy_a[k]), 32'(pos_q[k] >= 0));
        chk($sformatf("done%0d", k), 32'(fd_a[k]), 32'(pos_q[k] == flen(k) - 1));
        chk($sformatf("rdy%0d", k), 32'(rdy_a[k]), 32'(exp_rdy(k)));
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [31:0] cap[N];
  int          fd_cnt0;
  int          fd_at0;

  // Inputs change 1 time unit after the falling edge, away from both edges.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Shift n line samples into cap (first sample ends up most significant).
  task automatic grab(input int n, input int drop_valid_at);
    for (int k = 0; k < N; k++) cap[k] = '0;
    fd_cnt0 = 0;
    fd_at0  = -1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < N; k++) cap[k] = {cap[k][30:0], sout_a[k]};
      if (fd_a[0]) begin
        fd_cnt0++;
        if (fd_at0 < 0) fd_at0 = i;
      end
      if (i == drop_valid_at) din_valid = 1'b0;
      tick();
    end
  endtask

  // Two words with din_valid held high; the second is presented while the
  // first frame is still in flight and must follow with no gap.
  task automatic b2b(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [19:0] exp);
    din = a; din_valid = 1'b1;
    tick();
    din = b;
    grab(20, 11);
    chk({tag, "_bits"}, cap[0] & 32'hFFFFF, 32'(exp));
    chk({tag, "_done"}, 32'(fd_cnt0), 32'd2);
    repeat (15) tick();
  endtask

  initial begin
    // reset then idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("idle_rdy", 32'(rdy_a), 32'b111);
    chk("idle_sout", 32'(sout_a), 32'b000);

    // single frame of 8'hB1 on all three variants
    din = 8'hB1; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; din = 8'h00;
    grab(11, -1);
    chk("b1_msb", cap[0][10:1], 32'b1101100010);
    chk("b1_even", cap[1][10:0], 32'b11000110100);
    chk("b1_odd", cap[2][10:0], 32'b11000110110);
    chk("b1_fdpos", 32'(fd_at0), 32'd9);
    chk("b1_fdcnt", 32'(fd_cnt0), 32'd1);
    repeat (4) tick();

    // back-to-back streams, and din changing mid-frame
    b2b("a5_3c", 8'hA5, 8'h3C, {10'b1101001010, 10'b1001111000});
    b2b("ff_00", 8'hFF, 8'h00, {10'b1111111110, 10'b1000000000});

    // reset during data bit 4 of 8'hB1
    din = 8'hB1; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (5) tick();
    chk("mid_busy", 32'(busy_a), 32'b111);
    rst = 1'b1;
    tick();
    chk("rst_sout", 32'(sout_a), 32'b000);
    chk("rst_busy", 32'(busy_a), 32'b000);
    chk("rst_done", 32'(fd_a), 32'b000);
    chk("rst_rdy", 32'(rdy_a), 32'b000);
    rst = 1'b0;
    tick();
    din = 8'h0F; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    grab(11, -1);
    chk("0f_msb", cap[0][10:1], 32'b1000011110);
    chk("0f_fdcnt", 32'(fd_cnt0), 32'd1);
    repeat (4) tick();

    // random traffic with occasional resets
    repeat (3000) begin
      din       = W'($urandom);
      din_valid = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0; din_valid = 1'b0;
    repeat (20) tick();
    chk("end_idle", 32'(busy_a), 32'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
